// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: default instruction-memory geometry shared by the loader and its users
package imem_loader_pkg;
  localparam int IM_ADDRESSLEN = 12;
  localparam int IM_INSTLEN = 32;
  localparam int IM_XLEN = 8;
  localparam int IM_SIZE = 1024;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-wide memory write port, MSB first at the lowest address
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDRESSLEN,
  parameter int INST_W = IM_INSTLEN,
  parameter int BYTE_W = IM_XLEN,
  parameter int MEM_BYTES = IM_SIZE,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, words_d, mem_waddr_d;
  logic [1:0] idx_q, idx_d;
  logic [INST_W-1:0] word_q, word_d, word_sh;
  logic [BYTE_W-1:0] mem_wdata_d;
  logic last_q, last_d, in_ready_d, mem_we_d, busy_d, done_d, err_d, xfer, ovf;
  logic [ADDR_W:0] ptr_end;
  assign xfer = in_valid && in_ready;
  // one extra bit keeps the end-of-word address from wrapping past MEM_BYTES
  assign ptr_end = {1'b0, ptr_q} + (ADDR_W+1)'(4);
  assign ovf = ptr_end > (ADDR_W+1)'(MEM_BYTES);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    word_d = word_q;
    last_d = last_q;
    words_d = words_loaded;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = ACCEPT;
        ptr_d = ADDR_W'(BASE_ADDR);
        words_d = '0;
      end
      ACCEPT: if (xfer) begin
        word_d = in_data;
        last_d = in_last;
        idx_d = 2'd0;
        state_d = ovf ? ERR : WRITE;
      end
      WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          ptr_d = ptr_q + ADDR_W'(4);
          words_d = words_loaded + ADDR_W'(1);
          state_d = last_q ? DONE : ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == ACCEPT;
    mem_we_d = state_d == WRITE;
    busy_d = in_ready_d || mem_we_d;
    done_d = state_d == DONE;
    err_d = state_d == ERR;
    word_sh = word_d << (BYTE_W * idx_d);
    mem_waddr_d = mem_we_d ? ptr_d + ADDR_W'(idx_d) : '0;
    mem_wdata_d = mem_we_d ? word_sh[INST_W-1 -: BYTE_W] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= ADDR_W'(BASE_ADDR);
      idx_q <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      in_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      word_q <= word_d;
      last_q <= last_d;
      in_ready <= in_ready_d;
      mem_we <= mem_we_d;
      mem_waddr <= mem_waddr_d;
      mem_wdata <= mem_wdata_d;
      busy <= busy_d;
      done <= done_d;
      err <= err_d;
      words_loaded <= words_d;
    end
  end
endmodule
